// File: rtl/store_align_buffer.sv
// Store alignment and buffering: checks sw/sh/sb alignment, lane-shifts data and
// byte enables, and queues accepted stores in order toward data memory.
module store_align_buffer #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_wdata,
  input  logic [1:0]       st_type,
  output logic             st_exc,
  output logic             mem_req,
  input  logic             mem_ack,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_be,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] cnt_full = CNT_W'(DEPTH);

  logic [29:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [3:0]       be_q   [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;

  logic [1:0]  k;
  logic        legal;
  logic [3:0]  be_n;
  logic [31:0] data_n;
  logic        xfer;
  logic        push;
  logic        pop;

  assign k = st_addr[1:0];

  // Data is masked to the access size before shifting so unused lanes stay zero.
  always_comb begin
    legal  = 1'b0;
    be_n   = 4'b0000;
    data_n = 32'h0;
    case (st_type)
      2'b00: begin
        legal  = (k == 2'b00);
        be_n   = 4'b1111;
        data_n = st_wdata;
      end
      2'b01: begin
        legal  = ~k[0];
        be_n   = 4'b0011 << k;
        data_n = {16'h0, st_wdata[15:0]} << {k, 3'b000};
      end
      2'b10: begin
        legal  = 1'b1;
        be_n   = 4'b0001 << k;
        data_n = {24'h0, st_wdata[7:0]} << {k, 3'b000};
      end
      default: begin
        legal  = 1'b0;
      end
    endcase
  end

  assign st_ready = (count_q < cnt_full);
  assign mem_req  = (count_q != '0);
  assign xfer     = st_valid & st_ready;
  assign push     = xfer & legal;
  assign pop      = mem_req & mem_ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      st_exc  <= 1'b0;
    end else begin
      st_exc <= xfer & ~legal;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        be_q[i]   <= '0;
      end
    end else if (push) begin
      addr_q[wr_ptr] <= st_addr[31:2];
      data_q[wr_ptr] <= data_n;
      be_q[wr_ptr]   <= be_n;
    end
  end

  // Head is only presented while an entry is valid; stale slots never leak out.
  assign mem_addr  = mem_req ? {addr_q[rd_ptr], 2'b00} : 32'h0;
  assign mem_wdata = mem_req ? data_q[rd_ptr] : 32'h0;
  assign mem_be    = mem_req ? be_q[rd_ptr] : 4'b0000;
  assign count     = count_q;

endmodule

// File: tb/tb_store_align_buffer.sv
// Self-checking bench for store_align_buffer: table-driven single stores plus
// a scoreboard that follows every accepted store out to the memory side.
module tb_store_align_buffer;

  logic        clk;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_wdata;
  logic [1:0]  st_type;
  logic        st_exc;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [1:0]  count;

  store_align_buffer #(.DEPTH(2), .CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_wdata(st_wdata), .st_type(st_type),
    .st_exc(st_exc),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } entry_t;

  entry_t      sb_q[$];
  logic [31:0] drained[$];
  logic        exc_pend = 1'b0;

  // Reference: builds each byte lane from the source byte it should carry.
  function automatic void model(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                                output logic ok, output logic [3:0] be, output logic [31:0] wd);
    int  kk;
    int  src;
    logic sel;
    kk = int'(a[1:0]);
    ok = (t == 2'd0) ? (kk == 0) : (t == 2'd1) ? (a[0] == 1'b0) : (t == 2'd2);
    be = 4'b0000;
    wd = 32'h0;
    for (int l = 0; l < 4; l++) begin
      sel = 1'b0;
      src = 0;
      case (t)
        2'd0: begin sel = 1'b1; src = l; end
        2'd1: begin sel = ((l / 2) == (kk / 2)); src = l - kk; end
        2'd2: begin sel = (l == kk); src = 0; end
        default: sel = 1'b0;
      endcase
      if (ok && sel) begin
        be[l] = 1'b1;
        wd[8*l +: 8] = d[8*src +: 8];
      end
    end
  endfunction

  // Scoreboard monitor, sampled mid-cycle while inputs are stable.
  always @(negedge clk) begin
    logic        ok;
    logic [3:0]  be;
    logic [31:0] wd;
    entry_t      e;
    if (reset) begin
      sb_q.delete();
      exc_pend = 1'b0;
      check("rst_mem_req", {31'h0, mem_req}, 32'h0);
      check("rst_count", {30'h0, count}, 32'h0);
    end else begin
      check("st_exc", {31'h0, st_exc}, {31'h0, exc_pend});
      check("count", {30'h0, count}, sb_q.size());
      check("mem_req", {31'h0, mem_req}, {31'h0, sb_q.size() != 0});
      if (mem_req && mem_ack) begin
        if (sb_q.size() == 0) begin
          check("spurious_pop", {31'h0, mem_req}, 32'h0);
        end else begin
          e = sb_q.pop_front();
          check("sb_addr", mem_addr, e.addr);
          check("sb_be", {28'h0, mem_be}, {28'h0, e.be});
          check("sb_wdata", mem_wdata, e.data);
          drained.push_back(mem_addr);
        end
      end
      exc_pend = 1'b0;
      if (st_valid && st_ready) begin
        model(st_type, st_addr, st_wdata, ok, be, wd);
        if (ok) begin
          e.addr = {st_addr[31:2], 2'b00};
          e.be   = be;
          e.data = wd;
          sb_q.push_back(e);
        end else begin
          exc_pend = 1'b1;
        end
      end
    end
  end

  typedef struct {
    logic [1:0]  t;
    logic [31:0] a;
    logic [31:0] d;
    logic        exc;
    logic [3:0]  be;
    logic [31:0] wd;
  } vec_t;

  vec_t vecs[13];

  task automatic push_hold(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                           output logic ok);
    st_type  = t;
    st_addr  = a;
    st_wdata = d;
    st_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (st_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    st_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    reset    = 1'b1;
    st_valid = 1'b0;
    st_addr  = 32'h0;
    st_wdata = 32'h0;
    st_type  = 2'b00;
    mem_ack  = 1'b0;

    vecs[0]  = '{2'b10, 32'h0000_1003, 32'hAABB_CCDD, 1'b0, 4'b1000, 32'hDD00_0000};
    vecs[1]  = '{2'b01, 32'h0000_2002, 32'h1234_5678, 1'b0, 4'b1100, 32'h5678_0000};
    vecs[2]  = '{2'b01, 32'h0000_2001, 32'h1234_5678, 1'b1, 4'b0000, 32'h0};
    vecs[3]  = '{2'b00, 32'h0000_3002, 32'h1111_2222, 1'b1, 4'b0000, 32'h0};
    vecs[4]  = '{2'b11, 32'h0000_4000, 32'h1111_2222, 1'b1, 4'b0000, 32'h0};
    vecs[5]  = '{2'b00, 32'h0000_4000, 32'hDEAD_BEEF, 1'b0, 4'b1111, 32'hDEAD_BEEF};
    vecs[6]  = '{2'b10, 32'h0000_5000, 32'h1122_3344, 1'b0, 4'b0001, 32'h0000_0044};
    vecs[7]  = '{2'b10, 32'h0000_5001, 32'h1122_3344, 1'b0, 4'b0010, 32'h0000_4400};
    vecs[8]  = '{2'b10, 32'h0000_5002, 32'h1122_3344, 1'b0, 4'b0100, 32'h0044_0000};
    vecs[9]  = '{2'b01, 32'h0000_6000, 32'hCAFE_F00D, 1'b0, 4'b0011, 32'h0000_F00D};
    vecs[10] = '{2'b01, 32'h0000_6003, 32'hCAFE_F00D, 1'b1, 4'b0000, 32'h0};
    vecs[11] = '{2'b00, 32'h0000_7001, 32'hCAFE_F00D, 1'b1, 4'b0000, 32'h0};
    vecs[12] = '{2'b11, 32'h0000_7000, 32'hCAFE_F00D, 1'b1, 4'b0000, 32'h0};

    repeat (2) @(negedge clk);
    check("reset_st_exc", {31'h0, st_exc}, 32'h0);
    check("reset_mem_be", {28'h0, mem_be}, 32'h0);
    check("reset_mem_addr", mem_addr, 32'h0);
    check("reset_mem_wdata", mem_wdata, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_st_ready", {31'h0, st_ready}, 32'h1);

    // Single stores with the memory side always acking.
    mem_ack = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(posedge clk);
      #1;
      st_type  = vecs[i].t;
      st_addr  = vecs[i].a;
      st_wdata = vecs[i].d;
      st_valid = 1'b1;
      @(posedge clk);
      #1;
      st_valid = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_exc", i), {31'h0, st_exc}, {31'h0, vecs[i].exc});
      check($sformatf("v%0d_req", i), {31'h0, mem_req}, {31'h0, ~vecs[i].exc});
      check($sformatf("v%0d_be", i), {28'h0, mem_be}, {28'h0, vecs[i].be});
      check($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].wd);
      check($sformatf("v%0d_addr", i), mem_addr,
            vecs[i].exc ? 32'h0 : {vecs[i].a[31:2], 2'b00});
    end

    // Fill with ack low, third store held off, then a single ack cycle.
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    drained.delete();
    push_hold(2'b00, 32'h10, 32'h0000_0010, ok);
    check("t3_acc0", {31'h0, ok}, 32'h1);
    push_hold(2'b00, 32'h14, 32'h0000_0014, ok);
    check("t3_acc1", {31'h0, ok}, 32'h1);
    st_type  = 2'b00;
    st_addr  = 32'h18;
    st_wdata = 32'h0000_0018;
    st_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("t3_full_count", {30'h0, count}, 32'h2);
    check("t3_full_ready", {31'h0, st_ready}, 32'h0);
    @(posedge clk);
    #1;
    mem_ack = 1'b1;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    @(negedge clk);
    check("t4_pop_count", {30'h0, count}, 32'h1);
    check("t4_ready_after_pop", {31'h0, st_ready}, 32'h1);
    @(posedge clk);
    #1;
    st_valid = 1'b0;
    @(negedge clk);
    check("t4_refill_count", {30'h0, count}, 32'h2);
    mem_ack = 1'b1;
    repeat (5) @(negedge clk);
    check("t3_drain_n", drained.size(), 32'd3);
    if (drained.size() == 3) begin
      check("t3_order0", drained[0], 32'h10);
      check("t3_order1", drained[1], 32'h14);
      check("t3_order2", drained[2], 32'h18);
    end

    // Asynchronous reset with two entries pending.
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    push_hold(2'b10, 32'h0000_8001, 32'h0000_00AB, ok);
    push_hold(2'b00, 32'h0000_8004, 32'h1234_0000, ok);
    @(negedge clk);
    check("t6_pre_req", {31'h0, mem_req}, 32'h1);
    check("t6_pre_count", {30'h0, count}, 32'h2);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_req", {31'h0, mem_req}, 32'h0);
    check("t6_async_count", {30'h0, count}, 32'h0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    drained.delete();
    mem_ack = 1'b1;
    @(negedge clk);
    check("t6_ready", {31'h0, st_ready}, 32'h1);
    repeat (5) @(negedge clk);
    check("t6_no_old", drained.size(), 32'd0);
    check("t6_req_low", {31'h0, mem_req}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
